// File: rtl/llc_set_ctrl.sv
// -----------------------------------------------------------------------------
// llc_set_ctrl
//
// Sequencing controller for the LLC per-set buffer. For every accepted request
// it loads the set into the buffer, resolves the hit way or picks a victim,
// writes back a dirty victim, fetches the missing line and finally commits the
// buffer contents back to the SRAMs.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o     request handshake from the LLC pipeline
//   hit_i, hit_way_i              tag match result from the loaded buffer
//   evict_way_i                   buffered round-robin evict pointer
//   way_invalid_i, way_dirty_i    per-way state from the buffer
//   rd_mem_en_o, look_o           buffer load strobe (one cycle per request)
//   rst_state_o                   buffer clear pulse
//   incr_evict_way_buf_o          evict-pointer advance pulse
//   way_o                         selected way (buffer write / fill select)
//   mem_req_valid_o/_ready_i      memory request handshake
//   mem_req_hwrite_o              1 = victim writeback, 0 = line read
//   mem_rsp_valid_i/_ready_o      memory response handshake
//   done_valid_o/_ready_i         result handshake to the pipeline
//   done_hit_o                    request hit
//   set_wr_en_o                   one-cycle commit of the buffer to the SRAMs
// -----------------------------------------------------------------------------
module llc_set_ctrl #(
   parameter int unsigned WAYS     = 8,
   parameter int unsigned WAY_BITS = $clog2(WAYS)
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                req_valid_i,
   output logic                req_ready_o,

   input  logic                hit_i,
   input  logic [WAY_BITS-1:0] hit_way_i,
   input  logic [WAY_BITS-1:0] evict_way_i,
   input  logic [WAYS-1:0]     way_invalid_i,
   input  logic [WAYS-1:0]     way_dirty_i,

   output logic                rd_mem_en_o,
   output logic                look_o,
   output logic                rst_state_o,
   output logic                incr_evict_way_buf_o,
   output logic [WAY_BITS-1:0] way_o,

   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic                mem_req_hwrite_o,
   input  logic                mem_rsp_valid_i,
   output logic                mem_rsp_ready_o,

   output logic                done_valid_o,
   input  logic                done_ready_i,
   output logic                done_hit_o,
   output logic                set_wr_en_o
);

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StVictim,
      StWb,
      StFill,
      StWait,
      StDone,
      StCommit
   } state_e;

   state_e              state_q, state_d;
   logic [WAY_BITS-1:0] way_q, way_d;
   logic                use_ptr_q, use_ptr_d;
   logic                done_hit_q, done_hit_d;

   // --------------------------------------------------------------------------
   // Victim selection: rotating priority encoder starting at the evict pointer.
   // The invalid vector is doubled so a single indexed slice performs the
   // rotation; the lowest set bit of the rotated vector is the offset from the
   // pointer to the first invalid way.
   // --------------------------------------------------------------------------
   logic [2*WAYS-1:0]   inv_dbl;
   logic [WAYS-1:0]     inv_rot;
   logic [WAY_BITS-1:0] inv_offset;
   logic                any_invalid;
   logic [WAY_BITS-1:0] victim_way;

   assign inv_dbl = {way_invalid_i, way_invalid_i};
   assign inv_rot = inv_dbl[evict_way_i +: WAYS];

   always_comb begin
      inv_offset  = '0;
      any_invalid = 1'b0;
      // Descending scan so the lowest set bit wins.
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (inv_rot[i]) begin
            inv_offset  = WAY_BITS'(i);
            any_invalid = 1'b1;
         end
      end
   end

   // Carry drops naturally: the sum is WAY_BITS wide, giving modulo-WAYS wrap.
   assign victim_way = evict_way_i + inv_offset;

   // --------------------------------------------------------------------------
   // State and latched registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         way_q      <= '0;
         use_ptr_q  <= 1'b0;
         done_hit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         way_q      <= way_d;
         use_ptr_q  <= use_ptr_d;
         done_hit_q <= done_hit_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d              = state_q;
      way_d                = way_q;
      use_ptr_d            = use_ptr_q;
      done_hit_d           = done_hit_q;

      req_ready_o          = 1'b0;
      rd_mem_en_o          = 1'b0;
      look_o               = 1'b0;
      rst_state_o          = 1'b0;
      incr_evict_way_buf_o = 1'b0;
      mem_req_valid_o      = 1'b0;
      mem_req_hwrite_o     = 1'b0;
      mem_rsp_ready_o      = 1'b0;
      done_valid_o         = 1'b0;
      set_wr_en_o          = 1'b0;

      unique case (state_q)
         StIdle: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               // Load strobe fires in the accept cycle so the set is in the
               // buffer by the time we reach LOOKUP.
               rd_mem_en_o = 1'b1;
               look_o      = 1'b1;
               state_d     = StLookup;
            end
         end

         StLookup: begin
            done_hit_d = hit_i;
            if (hit_i) begin
               way_d   = hit_way_i;
               state_d = StDone;
            end else begin
               state_d = StVictim;
            end
         end

         StVictim: begin
            way_d     = victim_way;
            use_ptr_d = ~any_invalid;
            if (way_dirty_i[victim_way]) begin
               state_d = StWb;
            end else begin
               state_d = StFill;
            end
         end

         StWb: begin
            mem_req_valid_o  = 1'b1;
            mem_req_hwrite_o = 1'b1;
            if (mem_req_ready_i) begin
               state_d = StFill;
            end
         end

         StFill: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) begin
               state_d = StWait;
            end
         end

         StWait: begin
            mem_rsp_ready_o = 1'b1;
            if (mem_rsp_valid_i) begin
               // Only advance the pointer when it actually chose the victim.
               incr_evict_way_buf_o = use_ptr_q;
               done_hit_d           = 1'b0;
               state_d              = StDone;
            end
         end

         StDone: begin
            done_valid_o = 1'b1;
            if (done_ready_i) begin
               state_d = StCommit;
            end
         end

         StCommit: begin
            set_wr_en_o = 1'b1;
            rst_state_o = 1'b1;
            state_d     = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign way_o      = way_q;
   assign done_hit_o = done_hit_q;

endmodule

// File: tb/tb_llc_set_ctrl.sv
module tb_llc_set_ctrl;

   localparam int unsigned WAYS     = 8;
   localparam int unsigned WAY_BITS = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                req_valid_i = 1'b0;
   logic                req_ready_o;
   logic                hit_i = 1'b0;
   logic [WAY_BITS-1:0] hit_way_i = '0;
   logic [WAY_BITS-1:0] evict_way_i = '0;
   logic [WAYS-1:0]     way_invalid_i = '0;
   logic [WAYS-1:0]     way_dirty_i = '0;
   logic                rd_mem_en_o;
   logic                look_o;
   logic                rst_state_o;
   logic                incr_evict_way_buf_o;
   logic [WAY_BITS-1:0] way_o;
   logic                mem_req_valid_o;
   logic                mem_req_ready_i = 1'b0;
   logic                mem_req_hwrite_o;
   logic                mem_rsp_valid_i = 1'b0;
   logic                mem_rsp_ready_o;
   logic                done_valid_o;
   logic                done_ready_i = 1'b0;
   logic                done_hit_o;
   logic                set_wr_en_o;

   int checks = 0;
   int errors = 0;

   llc_set_ctrl #(
      .WAYS     (WAYS),
      .WAY_BITS (WAY_BITS)
   ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid_i          (req_valid_i),
      .req_ready_o          (req_ready_o),
      .hit_i                (hit_i),
      .hit_way_i            (hit_way_i),
      .evict_way_i          (evict_way_i),
      .way_invalid_i        (way_invalid_i),
      .way_dirty_i          (way_dirty_i),
      .rd_mem_en_o          (rd_mem_en_o),
      .look_o               (look_o),
      .rst_state_o          (rst_state_o),
      .incr_evict_way_buf_o (incr_evict_way_buf_o),
      .way_o                (way_o),
      .mem_req_valid_o      (mem_req_valid_o),
      .mem_req_ready_i      (mem_req_ready_i),
      .mem_req_hwrite_o     (mem_req_hwrite_o),
      .mem_rsp_valid_i      (mem_rsp_valid_i),
      .mem_rsp_ready_o      (mem_rsp_ready_o),
      .done_valid_o         (done_valid_o),
      .done_ready_i         (done_ready_i),
      .done_hit_o           (done_hit_o),
      .set_wr_en_o          (set_wr_en_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All outputs at reset value: only req_ready high, way 0, done_hit 0.
   task automatic chk_reset_outputs(input string tag);
      chk(tag, {req_ready_o, rd_mem_en_o, look_o, rst_state_o, incr_evict_way_buf_o,
                mem_req_valid_o, mem_req_hwrite_o, mem_rsp_ready_o, done_valid_o,
                done_hit_o, set_wr_en_o}, 32'b100_0000_0000);
      chk({tag, "_way"}, way_o, 0);
   endtask

   // One memory request phase (WB or FILL); ready withheld for 'stall' cycles.
   task automatic mem_phase(input logic hw_exp, input logic [2:0] ew, input int stall,
                            input bit stray_rsp);
      for (int i = 0; i <= stall; i++) begin
         @(negedge clk);
         mem_req_ready_i = (i == stall);
         mem_rsp_valid_i = stray_rsp;
         #1;
         chk("mreq_valid", mem_req_valid_o, 1);
         chk("mreq_hwrite", mem_req_hwrite_o, hw_exp);
         chk("mreq_way", way_o, ew);
         chk("mreq_quiet", {mem_rsp_ready_o, incr_evict_way_buf_o, done_valid_o, rd_mem_en_o}, 0);
      end
   endtask

   // Full request from the pipeline's point of view. Expected results come from
   // the replacement rules: hit -> hit way; else first invalid way scanning
   // from the evict pointer modulo WAYS, else the pointer itself.
   task automatic txn(input logic h, input logic [2:0] hw, input logic [2:0] ev,
                      input logic [7:0] inv, input logic [7:0] dty, input int req_stall,
                      input int done_stall, input int rsp_stall, input bit stray,
                      input bit abort_wait);
      logic [2:0] ew;
      logic       found;
      logic       exp_wb;
      logic       exp_incr;
      found = 1'b0;
      ew    = ev;
      for (int i = 0; i < 8; i++) begin
         if (!found && inv[(int'(ev) + i) % 8]) begin
            found = 1'b1;
            ew    = 3'((int'(ev) + i) % 8);
         end
      end
      if (h) ew = hw;
      exp_wb   = !h && dty[ew];
      exp_incr = !h && !found;

      // Accept cycle
      @(negedge clk);
      hit_i = h; hit_way_i = hw; evict_way_i = ev; way_invalid_i = inv; way_dirty_i = dty;
      req_valid_i = 1'b1;
      #1;
      chk("accept_ready", req_ready_o, 1);
      chk("load_strobe", {rd_mem_en_o, look_o}, 2'b11);

      // LOOKUP
      @(negedge clk);
      req_valid_i = stray;
      #1;
      chk("lookup_busy", {req_ready_o, rd_mem_en_o, look_o, mem_req_valid_o, done_valid_o}, 0);

      if (!h) begin
         // VICTIM
         @(negedge clk);
         #1;
         chk("victim_quiet", {mem_req_valid_o, done_valid_o, rd_mem_en_o, req_ready_o}, 0);
         if (exp_wb) mem_phase(1'b1, ew, req_stall, stray);
         mem_phase(1'b0, ew, req_stall, 1'b0);
         // WAIT
         for (int i = 0; i < rsp_stall; i++) begin
            @(negedge clk);
            mem_req_ready_i = 1'b0;
            mem_rsp_valid_i = 1'b0;
            #1;
            chk("wait_hold", {mem_req_valid_o, mem_rsp_ready_o, incr_evict_way_buf_o,
                              done_valid_o, rd_mem_en_o}, 5'b01000);
         end
         @(negedge clk);
         mem_req_ready_i = 1'b0;
         mem_rsp_valid_i = 1'b1;
         #1;
         chk("rsp_ready", mem_rsp_ready_o, 1);
         chk("wait_req_low", mem_req_valid_o, 0);
         chk("incr_pulse", incr_evict_way_buf_o, exp_incr);
         if (abort_wait) begin
            #1 rst = 1'b0;
            #1;
            chk_reset_outputs("reset_in_wait");
            @(negedge clk);
            mem_rsp_valid_i = 1'b0;
            #1;
            chk_reset_outputs("reset_held");
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk_reset_outputs("reset_release");
            return;
         end
      end

      // DONE, with done_ready withheld for done_stall cycles
      for (int i = 0; i <= done_stall; i++) begin
         @(negedge clk);
         mem_rsp_valid_i = 1'b0;
         done_ready_i    = (i == done_stall);
         #1;
         chk("done_valid", done_valid_o, 1);
         chk("done_hit", done_hit_o, h);
         chk("done_way", way_o, ew);
         chk("done_quiet", {mem_req_valid_o, mem_rsp_ready_o, set_wr_en_o,
                            incr_evict_way_buf_o, rd_mem_en_o, req_ready_o}, 0);
      end

      // COMMIT
      @(negedge clk);
      done_ready_i = 1'b0;
      req_valid_i  = 1'b0;
      #1;
      chk("commit", {set_wr_en_o, rst_state_o, done_valid_o, req_ready_o}, 4'b1100);
      chk("commit_way", way_o, ew);

      // Back in IDLE
      @(negedge clk);
      #1;
      chk("back_idle", {req_ready_o, set_wr_en_o, rst_state_o, rd_mem_en_o}, 4'b1000);
   endtask

   initial begin
      // Reset
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("reset_async");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_outputs("reset_idle");

      // Hit on way 5, done_ready immediately
      txn(1'b1, 3'd5, 3'd0, 8'h00, 8'hFF, 0, 0, 0, 1'b0, 1'b0);

      // Invalid-way scan wraps from pointer 6 to way 0; clean, no pointer advance
      txn(1'b0, 3'd0, 3'd6, 8'b0000_0011, 8'hFE, 0, 0, 0, 1'b0, 1'b0);

      // Pointer victim 7, dirty: writeback then fill, one advance pulse
      txn(1'b0, 3'd0, 3'd7, 8'h00, 8'h80, 0, 0, 1, 1'b0, 1'b0);

      // Backpressure on memory request and done
      txn(1'b0, 3'd0, 3'd2, 8'h00, 8'h04, 4, 3, 2, 1'b0, 1'b0);

      // Stray response in IDLE
      @(negedge clk);
      mem_rsp_valid_i = 1'b1;
      #1;
      chk("stray_idle_rsp_ready", mem_rsp_ready_o, 0);
      chk("stray_idle_state", {req_ready_o, incr_evict_way_buf_o, done_valid_o}, 3'b100);
      @(negedge clk);
      mem_rsp_valid_i = 1'b0;
      #1;
      chk("stray_idle_after", {req_ready_o, done_valid_o, mem_req_valid_o}, 3'b100);

      // Stray response during WB, req_valid held while busy
      txn(1'b0, 3'd0, 3'd3, 8'h00, 8'h08, 2, 1, 1, 1'b1, 1'b0);

      // Reset in WAIT, then a normal hit
      txn(1'b0, 3'd0, 3'd1, 8'h00, 8'h00, 0, 0, 1, 1'b0, 1'b1);
      txn(1'b1, 3'd2, 3'd4, 8'h10, 8'h00, 0, 1, 0, 1'b0, 1'b0);

      // Randomized requests
      for (int n = 0; n < 40; n++) begin
         logic [7:0] rinv;
         rinv = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         txn(1'($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom), rinv, 8'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/llc_set_ctrl.md
# llc_set_ctrl

Sequencing controller for the LLC per-set buffer. On each request it loads one set from the LLC SRAMs into the buffer, resolves hit or victim way, writes back a dirty victim, fetches the missing line, and commits the set back to the SRAMs. It sits between the LLC request pipeline and the set buffer and memory interface, and owns the buffer load, fill-way select, evict-pointer advance and buffer clear controls.

## Interface
- WAYS, 8, number of LLC ways; power of two, 2..32
- WAY_BITS, $clog2(WAYS), width of way indices
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- req_valid / req_ready  in / out  1  request handshake from the LLC request pipeline
- hit  in  1  tag match computed combinationally from the loaded buffer; valid in LOOKUP
- hit_way  in  WAY_BITS  matching way; valid when hit
- evict_way  in  WAY_BITS  buffered round-robin evict pointer
- way_invalid  in  WAYS  per-way "state == INVALID" from the buffer
- way_dirty  in  WAYS  per-way dirty bit from the buffer
- rd_mem_en, look  out  1  buffer load strobe; both high for exactly one cycle per request
- rst_state  out  1  buffer clear pulse
- incr_evict_way_buf  out  1  evict-pointer advance pulse
- way  out  WAY_BITS  selected way; drives the buffer's per-way write and fill select
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_hwrite  out  1  1 = writeback of the victim line, 0 = line read
- mem_rsp_valid / mem_rsp_ready  in / out  1  memory response handshake; the buffer captures the line on valid&&ready
- done_valid / done_ready  out / in  1  result handshake to the pipeline
- done_hit  out  1  request hit
- set_wr_en  out  1  one-cycle commit of the buffer contents to the SRAMs

## Operation
- States: IDLE, LOOKUP, VICTIM, WB, FILL, WAIT, DONE, COMMIT.
- IDLE: req_ready=1. On req_valid, pulse rd_mem_en=look=1 in the same cycle, then go to LOOKUP.
- LOOKUP: buffer now holds the set.
  - hit=1: latch way=hit_way and done_hit=1, then go to DONE.
  - hit=0: go to VICTIM.
- VICTIM: rotating priority encoder picks the first way with way_invalid=1, scanning evict_way, evict_way+1, ... modulo WAYS.
  - If no way is invalid, victim = evict_way.
  - Latch way=victim. Latch use_ptr=1 if no way was invalid.
  - Go to WB if way_dirty[victim]=1, else go to FILL.
- WB: mem_req_valid=1, mem_req_hwrite=1. On mem_req_ready, go to FILL.
- FILL: mem_req_valid=1, mem_req_hwrite=0. On mem_req_ready, go to WAIT.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid:
  - pulse incr_evict_way_buf if use_ptr=1;
  - done_hit=0;
  - go to DONE.
- DONE: done_valid=1; way and done_hit are held stable. On done_ready, go to COMMIT.
- COMMIT: set_wr_en=1 and rst_state=1 for one cycle, then go to IDLE.
- The way output holds its value from latch until COMMIT. mem_req_valid, once asserted, stays high until accepted.
- Evict-pointer arithmetic wraps modulo WAYS (WAY_BITS-wide add, carry dropped).

## Timing
- Reset (async assert, sync deassert): state=IDLE, way=0, use_ptr=0, done_hit=0; every handshake and strobe output is 0 except req_ready=1.
- Hit latency: req accept (cycle 0), LOOKUP (1), done_valid in cycle 2. COMMIT follows the cycle after done_ready.
- Clean miss path:
  - LOOKUP (1), VICTIM (2);
  - FILL mem_req_valid from cycle 3;
  - WAIT begins the cycle after mem_req_ready;
  - DONE begins the cycle after mem_rsp_valid.
- A dirty miss adds the WB phase: at least 1 cycle plus ready stalls.
- mem_rsp_valid outside WAIT is ignored (mem_rsp_ready=0). req_valid outside IDLE is ignored (req_ready=0).
- Back-to-back requests: a new request can be accepted in the cycle after COMMIT.
- Reset asserted mid-operation aborts immediately: no COMMIT, no incr pulse, and any pending mem_req_valid drops asynchronously.

## Test plan
- Hit: WAYS=8, req_valid with hit=1, hit_way=5, done_ready=1 -> rd_mem_en/look pulse at cycle 0; done_valid, done_hit=1, way=5 at cycle 2; set_wr_en and rst_state at cycle 3; req_ready=1 at cycle 4.
- Invalid-way wrap: evict_way=6, way_invalid=8'b0000_0011, hit=0 -> way=0, no WB, one FILL request, no incr_evict_way_buf.
- Dirty pointer victim: way_invalid=0, evict_way=7, way_dirty[7]=1 -> WB request (hwrite=1), then FILL (hwrite=0); incr_evict_way_buf pulses exactly once, in the mem_rsp cycle; done_hit=0 and way=7.
- Backpressure: mem_req_ready low for 4 cycles, then done_ready low for 3 cycles -> mem_req_valid and done_valid stay high and way stays stable throughout; exactly one set_wr_en.
- Stray signals: mem_rsp_valid pulsed during IDLE and WB, req_valid held high while busy -> no state change and no extra load strobe.
- Reset in WAIT: rst low -> all outputs at reset values within the same cycle; after release, a new hit request completes normally.
